ntt_unload: RTL and testbench
=============================

NTT_UNLOAD -- requirements
Module: ntt_unload

Interface
REQ-001 Parameter DATA_W, default 32: coefficient and dout0 word width.
REQ-002 Parameter N_MAX, default 1024: result buffer depth in coefficients.
REQ-003 Parameter PE_DEPTH, default 3: log2 of the core's PE count; sets words per burst.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to arm a capture.
REQ-007 ring_size  in  12  polynomial length (power of two, 16..N_MAX); sampled on accepted start.
REQ-008 q  in  DATA_W  modulus; sampled on accepted start.
REQ-009 done  in  1  NTT core completion flag.
REQ-010 dout0  in  DATA_W  NTT core result stream.
REQ-011 rd_addr  in  log2(N_MAX)  result buffer read address.
REQ-012 rd_data  out  DATA_W  buffer word at rd_addr; registered, 1-cycle latency.
REQ-013 busy  out  1  high in ARMED and BURST.
REQ-014 complete  out  1  one-cycle pulse when capture finishes.
REQ-015 word_cnt  out  log2(N_MAX)+1  nonzero words captured in the current or last capture.
REQ-016 overflow  out  1  sticky; set when a word arrives with word_cnt == ring_size.

Function
REQ-017 FSM states: IDLE, ARMED, BURST, FIN; one state register.
REQ-018 IDLE: start=1 -> ARMED; latch ring_size and q; clear word_cnt, burst counter, overflow.
REQ-019 start is ignored in ARMED, BURST, FIN.
REQ-020 ARMED: done=1 on a clock edge -> BURST; dout0 is not captured on that edge.
REQ-021 BURST: each edge samples dout0; nonzero word = data; zero word = burst separator.
REQ-022 Data word with global index m = word_cnt: write address m>>1 if m even, (m>>1)+ring_size/2 if m odd.
REQ-023 Stored value = dout0-q if dout0 >= q (unsigned), else dout0; one conditional subtraction only.
REQ-024 Each data word increments word_cnt by 1.
REQ-025 Separator increments burst counter; empty bursts (consecutive separators) count.
REQ-026 Burst target B = ring_size >> (PE_DEPTH+1); the edge consuming separator number B -> FIN.
REQ-027 FIN lasts one cycle, pulses complete, returns to IDLE.
REQ-028 Data word when word_cnt == ring_size: no write, word_cnt holds, overflow set; capture continues.
REQ-029 done is level-insensitive outside ARMED; done held high has no effect after entering BURST.
REQ-030 Buffer writes occur only in BURST; rd_data is readable in every state, including during capture.
REQ-031 Read/write collision at the same address returns the old word.
REQ-032 No timeout; ARMED and BURST wait indefinitely.

Reset
REQ-033 reset low, at any time including mid-burst: state=IDLE, busy=0, complete=0, overflow=0, word_cnt=0, burst counter=0.
REQ-034 Buffer contents are not cleared by reset; rd_data is undefined until the first read after reset.
REQ-035 Deassertion is synchronised internally; the first edge after deassertion may accept start.

Verification
REQ-036 ring_size=256, q=7342081, start, done, then 16 bursts of 16 words with value m+1, each followed by one zero -> buf[0]=1, buf[128]=2, buf[1]=3, buf[255]=256; word_cnt=256; complete pulses on the edge after the 16th separator.
REQ-037 Same run with word m=0 equal to 7342085 and m=1 equal to 7342081 -> buf[0]=4, buf[128]=0.
REQ-038 ring_size=256 with 17 words in the last burst -> overflow=1, word_cnt=256, buf unchanged by the 17th word, complete still pulses.
REQ-039 reset pulled low after 5 bursts -> busy=0, word_cnt=0; a new start followed by a full 256-word run yields correct buffer contents.
REQ-040 start asserted in ARMED and in BURST -> ignored; ring_size=1024 run -> B=64, complete only after the 64th separator, including runs containing empty bursts.

Source files
------------

// File: rtl/ntt_unload_if.sv
// Purpose: bundles the NTT unload control, result stream and buffer read port.
// Latency: none, wiring only; rd_data timing is set by the module behind the slave modport.
// Backpressure: none; the core stream is sampled every cycle, readers poll busy/complete.
interface ntt_unload_if #(
  parameter int DATA_W = 32,
  parameter int N_MAX  = 1024
);
  localparam int AW = $clog2(N_MAX);

  logic              start;
  logic [11:0]       ring_size;
  logic [DATA_W-1:0] q;
  logic              done;
  logic [DATA_W-1:0] dout0;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              complete;
  logic [AW:0]       word_cnt;
  logic              overflow;

  modport master (
    output start, ring_size, q, done, dout0, rd_addr,
    input  rd_data, busy, complete, word_cnt, overflow
  );

  modport slave (
    input  start, ring_size, q, done, dout0, rd_addr,
    output rd_data, busy, complete, word_cnt, overflow
  );
endinterface

// File: rtl/ntt_unload.sv
// Purpose: captures an NTT core result stream into a bit-reversal-split buffer, reduced mod q once.
// Latency: a word is written on the edge that samples it; rd_data is registered, 1 cycle after rd_addr.
// Backpressure: none; the core stream cannot be stalled, excess words are dropped and flagged.
module ntt_unload #(
  parameter int DATA_W   = 32,
  parameter int N_MAX    = 1024,
  parameter int PE_DEPTH = 3
) (
  input  logic         i_clk,
  input  logic         i_reset,
  ntt_unload_if.slave  bus
);
  localparam int AW = $clog2(N_MAX);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BURST, S_FIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [11:0]       r_ring_size;
  logic [11:0]       r_burst_cnt;
  logic [DATA_W-1:0] r_q;
  logic [CW-1:0]     r_word_cnt;
  logic              r_overflow;
  logic [DATA_W-1:0] r_mem [N_MAX];
  logic [DATA_W-1:0] r_rd_data;

  logic              w_accept;
  logic              w_wr;
  logic              w_sep;
  logic              w_ovf;
  logic              w_busy;
  logic              w_complete;
  logic              w_is_data;
  logic              w_full;
  logic [11:0]       w_burst_tgt;
  logic [AW-1:0]     w_wr_addr;
  logic [DATA_W-1:0] w_red;

  // A zero word from the core marks the end of a PE burst; anything else is data.
  assign w_is_data   = (bus.dout0 != '0);
  assign w_full      = (12'(r_word_cnt) == r_ring_size);
  // One separator per group of 2^(PE_DEPTH+1) coefficients.
  assign w_burst_tgt = r_ring_size >> (PE_DEPTH + 1);
  // Even indices fill the lower half, odd indices the upper half.
  assign w_wr_addr   = r_word_cnt[0] ? (AW'(r_word_cnt >> 1) + AW'(r_ring_size >> 1))
                                     : AW'(r_word_cnt >> 1);
  // Core output is below 2q, so a single conditional subtraction fully reduces it.
  assign w_red       = (bus.dout0 >= r_q) ? (bus.dout0 - r_q) : bus.dout0;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_wr       = 1'b0;
    w_sep      = 1'b0;
    w_ovf      = 1'b0;
    w_busy     = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_ARMED;
        end
      end
      S_ARMED: begin
        w_busy = 1'b1;
        if (bus.done) w_next = S_BURST;
      end
      S_BURST: begin
        w_busy = 1'b1;
        if (w_is_data) begin
          if (w_full) w_ovf = 1'b1;
          else        w_wr  = 1'b1;
        end else begin
          w_sep = 1'b1;
          if ((r_burst_cnt + 12'd1) == w_burst_tgt) w_next = S_FIN;
        end
      end
      S_FIN: begin
        w_complete = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture parameters and progress counters; overflow stays set until the next start.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ring_size <= '0;
      r_q         <= '0;
      r_word_cnt  <= '0;
      r_burst_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ring_size <= bus.ring_size;
        r_q         <= bus.q;
        r_word_cnt  <= '0;
        r_burst_cnt <= '0;
        r_overflow  <= 1'b0;
      end
      if (w_wr)  r_word_cnt  <= r_word_cnt + CW'(1);
      if (w_ovf) r_overflow  <= 1'b1;
      if (w_sep) r_burst_cnt <= r_burst_cnt + 12'd1;
    end
  end

  // Result buffer: not reset, read-before-write so a same-address collision returns the old word.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[w_wr_addr] <= w_red;
    r_rd_data <= r_mem[bus.rd_addr];
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.busy     = w_busy;
  assign bus.complete = w_complete;
  assign bus.word_cnt = r_word_cnt;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_ntt_unload.sv
// Purpose: directed checks of ntt_unload capture, reduction, overflow, reset and burst counting.
// Latency: inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Backpressure: none; the bench drives the result stream every cycle.
module tb_ntt_unload;
    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_idx = 0;
    int   vbase = 1;

    ntt_unload_if #(.DATA_W(32), .N_MAX(1024)) bus ();

    ntt_unload #(.DATA_W(32), .N_MAX(1024), .PE_DEPTH(3)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Accept start, then move to BURST with a nonzero word present that must not be captured.
    task automatic arm(input logic [11:0] rs, input logic [31:0] qq);
        bus.start = 1'b1; bus.ring_size = rs; bus.q = qq;
        tick();
        bus.start = 1'b0;
        bus.dout0 = 32'h55;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        m_idx = 0;
    endtask

    task automatic send(input logic [31:0] v);
        bus.dout0 = v;
        tick();
        m_idx++;
    endtask

    task automatic words(input int n);
        for (int i = 0; i < n; i++) send(32'(m_idx + vbase));
    endtask

    task automatic sep();
        bus.dout0 = '0;
        tick();
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string tag);
        bus.rd_addr = 10'(a);
        tick();
        chk(tag, bus.rd_data, exp);
    endtask

    initial begin
        #2000000;
        errors++;
        $error("FAIL timeout: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        bus.start = 1'b0; bus.ring_size = '0; bus.q = '0; bus.done = 1'b0;
        bus.dout0 = '0; bus.rd_addr = '0;

        // Reset state
        #12;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_complete", bus.complete, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_word_cnt", bus.word_cnt, 11'd0);
        tick();
        i_reset = 1'b1;
        tick();

        // Run 1: 16 bursts of 16 words, done held high throughout the burst phase
        vbase = 1;
        arm(12'd256, 32'd7342081);
        bus.done = 1'b1;
        chk("r1_busy", bus.busy, 1'b1);
        for (int b = 0; b < 16; b++) begin
            words(16);
            sep();
            if (b == 14) chk("r1_no_early_complete", bus.complete, 1'b0);
        end
        chk("r1_complete", bus.complete, 1'b1);
        bus.done = 1'b0;
        tick();
        chk("r1_complete_pulse", bus.complete, 1'b0);
        chk("r1_idle_busy", bus.busy, 1'b0);
        chk("r1_word_cnt", bus.word_cnt, 11'd256);
        rd(0, 32'd1, "r1_buf0");
        rd(128, 32'd2, "r1_buf128");
        rd(1, 32'd3, "r1_buf1");
        rd(255, 32'd256, "r1_buf255");

        // Run 2: reduction of the first two words, and read/write collision at address 0
        arm(12'd256, 32'd7342081);
        bus.rd_addr = 10'd0;
        send(32'd7342085);
        chk("r2_collision_old", bus.rd_data, 32'd1);
        send(32'd7342081);
        words(14);
        sep();
        for (int b = 1; b < 16; b++) begin words(16); sep(); end
        chk("r2_complete", bus.complete, 1'b1);
        rd(0, 32'd4, "r2_buf0_reduced");
        rd(128, 32'd0, "r2_buf128_reduced");
        rd(1, 32'd3, "r2_buf1");

        // Run 3: a 17th word in the last burst overflows
        arm(12'd256, 32'd7342081);
        for (int b = 0; b < 15; b++) begin words(16); sep(); end
        words(16);
        send(32'h0000ABCD);
        chk("r3_overflow", bus.overflow, 1'b1);
        chk("r3_word_cnt_hold", bus.word_cnt, 11'd256);
        sep();
        chk("r3_complete", bus.complete, 1'b1);
        tick();
        chk("r3_overflow_sticky", bus.overflow, 1'b1);
        rd(128, 32'd2, "r3_buf128_untouched");
        rd(0, 32'd1, "r3_buf0");

        // Run 4: reset mid-capture, then an immediate restart on the first edge
        vbase = 1000;
        arm(12'd256, 32'd7342081);
        chk("r4_overflow_cleared", bus.overflow, 1'b0);
        for (int b = 0; b < 5; b++) begin words(16); sep(); end
        #3;
        i_reset = 1'b0;
        #1;
        chk("r4_rst_busy", bus.busy, 1'b0);
        chk("r4_rst_word_cnt", bus.word_cnt, 11'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        arm(12'd256, 32'd7342081);
        chk("r4_restart_busy", bus.busy, 1'b1);
        for (int b = 0; b < 16; b++) begin words(16); sep(); end
        chk("r4_complete", bus.complete, 1'b1);
        chk("r4_word_cnt", bus.word_cnt, 11'd256);
        rd(0, 32'd1000, "r4_buf0");
        rd(128, 32'd1001, "r4_buf128");
        rd(1, 32'd1002, "r4_buf1");
        rd(255, 32'd1255, "r4_buf255");

        // Run 5: ring_size 1024 with empty bursts; start retried with ring_size 256 in ARMED and BURST
        vbase = 1;
        bus.start = 1'b1; bus.ring_size = 12'd1024; bus.q = 32'd7342081;
        tick();
        bus.ring_size = 12'd256;
        tick();
        bus.start = 1'b0;
        chk("r5_armed_busy", bus.busy, 1'b1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        m_idx = 0;
        for (int b = 0; b < 64; b++) begin
            if (b == 20) bus.start = 1'b1;
            if (b % 8 != 3) words(16);
            bus.start = 1'b0;
            sep();
            if (b == 15) chk("r5_no_complete_at16", bus.complete, 1'b0);
            if (b == 62) chk("r5_no_complete_at63", bus.complete, 1'b0);
        end
        chk("r5_complete_at64", bus.complete, 1'b1);
        chk("r5_word_cnt", bus.word_cnt, 11'd896);
        rd(0, 32'd1, "r5_buf0");
        rd(512, 32'd2, "r5_buf512");
        rd(1, 32'd3, "r5_buf1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
